dmem_ctrl: RTL and testbench

- Data-memory slave on the single-cycle rv32i core's data port.
- Consumes the core's address, read/write strobes, byte mask and store data. Returns load data with a one-cycle valid pulse after a configurable number of wait states.
- Holds a word-organised on-chip RAM with byte-granular writes.
- Flags misaligned, out-of-range and conflicting requests so the core can trap.

---
 rtl/dmem_ctrl_if.sv | 38 +++
 rtl/dmem_ctrl.sv | 151 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Data-port bundle between the rv32i core (master) and the data-memory
// controller (slave). The core drives the request half and watches the
// completion half.
interface dmem_ctrl_if;
  logic [31:0] ip_data_addr;
  logic        ip_data_wr;
  logic [3:0]  ip_data_mask;
  logic [31:0] ip_data_from_proc;
  logic        ip_data_rd;
  logic        op_data_valid;
  logic [31:0] op_data_to_proc;
  logic        op_data_err;
  logic        op_busy;

  modport master (
    output ip_data_addr,
    output ip_data_wr,
    output ip_data_mask,
    output ip_data_from_proc,
    output ip_data_rd,
    input  op_data_valid,
    input  op_data_to_proc,
    input  op_data_err,
    input  op_busy
  );

  modport slave (
    input  ip_data_addr,
    input  ip_data_wr,
    input  ip_data_mask,
    input  ip_data_from_proc,
    input  ip_data_rd,
    output op_data_valid,
    output op_data_to_proc,
    output op_data_err,
    output op_busy
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory slave for the single-cycle rv32i core.
// Word-organised RAM with byte-lane writes, a programmable number of wait
// states, and an error flag for misaligned, out-of-range or rd+wr requests.
// Every output comes straight from a flop.
module dmem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
  input logic        clk,
  input logic        reset,
  dmem_ctrl_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [32:0] SPAN  = 33'd4 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          r_state;
  logic [3:0]      r_count;
  logic [31:0]     r_addr;
  logic [3:0]      r_mask;
  logic [31:0]     r_wdata;
  logic            r_rd;
  logic            r_wr;
  logic            r_valid;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic            r_busy;
  logic [31:0]     r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_access;
  logic [31:0]           w_addr;
  logic [3:0]            w_mask;
  logic [31:0]           w_wdata;
  logic                  w_rd;
  logic                  w_wr;
  logic [31:0]           w_offset;
  logic                  w_inRange;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_index;
  logic [31:0]           w_rword;

  // Pick the request that is touching memory this cycle: with no wait states
  // it is the live request being accepted, otherwise the captured copy as the
  // countdown expires. Decode and error checks are done on that request.
  always_comb begin
    w_accept = (r_state == IDLE) && (bus.ip_data_rd || bus.ip_data_wr);
    if (LATENCY == 0) begin
      w_access = w_accept;
      w_addr   = bus.ip_data_addr;
      w_mask   = bus.ip_data_mask;
      w_wdata  = bus.ip_data_from_proc;
      w_rd     = bus.ip_data_rd;
      w_wr     = bus.ip_data_wr;
    end else begin
      w_access = (r_state == WAIT) && (r_count == 4'd0);
      w_addr   = r_addr;
      w_mask   = r_mask;
      w_wdata  = r_wdata;
      w_rd     = r_rd;
      w_wr     = r_wr;
    end
    w_offset  = w_addr - BASE_ADDR;
    w_inRange = (w_addr >= BASE_ADDR) && ({1'b0, w_offset} < SPAN);
    w_err     = (w_addr[1:0] != 2'b00) || !w_inRange || (w_rd && w_wr);
    w_index   = w_offset[ADDR_WIDTH+1:2];
    w_rword   = r_mem[w_index];
  end

  // Request FSM plus the RAM commit and response registers. The RAM write
  // sits in the non-reset branch so a store caught by reset never lands;
  // RAM contents themselves are deliberately left alone by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= 4'd0;
      r_addr  <= 32'd0;
      r_mask  <= 4'd0;
      r_wdata <= 32'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_valid <= 1'b0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      if (w_access && w_wr && !w_err) begin
        for (int i = 0; i < 4; i++) begin
          if (w_mask[i]) begin
            r_mem[w_index][8*i +: 8] <= w_wdata[8*i +: 8];
          end
        end
      end

      if (w_access) begin
        r_valid <= 1'b1;
        r_err   <= w_err;
        r_rdata <= (w_rd && !w_err) ? w_rword : 32'd0;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr  <= bus.ip_data_addr;
            r_mask  <= bus.ip_data_mask;
            r_wdata <= bus.ip_data_from_proc;
            r_rd    <= bus.ip_data_rd;
            r_wr    <= bus.ip_data_wr;
            r_busy  <= 1'b1;
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_count <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (r_count == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_data_valid   = r_valid;
  assign bus.op_data_to_proc = r_rdata;
  assign bus.op_data_err     = r_err;
  assign bus.op_busy         = r_busy;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl. Three instances run with 1, 0 and 15
// wait states; a word-array reference model predicts every response.
module tb_dmem_ctrl;

  localparam longint unsigned BASE  = 64'h1000;
  localparam int              DEPTH = 1024;

  logic clk;
  logic reset;

  logic [31:0] reqAddr [3];
  logic [31:0] reqData [3];
  logic [3:0]  reqMask [3];
  logic [2:0]  reqRd;
  logic [2:0]  reqWr;

  logic [2:0]  obsValid;
  logic [2:0]  obsErr;
  logic [2:0]  obsBusy;
  logic [31:0] obsData [3];

  logic [31:0] refMem [3][DEPTH];

  int checkCount = 0;
  int errorCount = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gInst
    dmem_ctrl_if bus ();

    assign bus.ip_data_addr      = reqAddr[g];
    assign bus.ip_data_wr        = reqWr[g];
    assign bus.ip_data_mask      = reqMask[g];
    assign bus.ip_data_from_proc = reqData[g];
    assign bus.ip_data_rd        = reqRd[g];
    assign obsValid[g]           = bus.op_data_valid;
    assign obsErr[g]             = bus.op_data_err;
    assign obsBusy[g]            = bus.op_busy;
    assign obsData[g]            = bus.op_data_to_proc;

    dmem_ctrl #(
      .ADDR_WIDTH(10),
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 0 : 15)),
      .BASE_ADDR(32'h0000_1000)
    ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
    );
  end

  function automatic int latOf(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 15);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int k, input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [3:0] mask, input logic [31:0] data);
    reqRd[k]   = rd;
    reqWr[k]   = wr;
    reqAddr[k] = addr;
    reqMask[k] = mask;
    reqData[k] = data;
  endtask

  // Reference model: decode the byte address arithmetically and apply the
  // request to the word array; returns the expected err flag and load data.
  function automatic void predict(input int k, input logic rd, input logic wr, input logic [31:0] addr,
                                  input logic [3:0] mask, input logic [31:0] data,
                                  output logic expErr, output logic [31:0] expData);
    longint unsigned a;
    bit              inRange;
    int              idx;
    logic [31:0]     laneMask;
    a       = addr;
    inRange = (a >= BASE) && (a < BASE + 4 * DEPTH);
    expErr  = ((a % 4) != 0) || !inRange || (rd && wr);
    expData = 32'd0;
    if (!expErr) begin
      idx = int'((a - BASE) / 4);
      if (wr) begin
        for (int i = 0; i < 4; i++) begin
          if (mask[i]) begin
            laneMask       = 32'hFF << (8 * i);
            refMem[k][idx] = (refMem[k][idx] & ~laneMask) | (data & laneMask);
          end
        end
      end else begin
        expData = refMem[k][idx];
      end
    end
  endfunction

  // Issue one request the way the core does: present at a falling edge,
  // hold until valid is seen, then drop it and check the controller idles.
  task automatic doRequest(input int k, input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] data,
                           output logic [31:0] gotData, output logic gotErr);
    logic        expErr;
    logic [31:0] expData;
    int          cycles;
    bit          seen;
    string       tag;
    predict(k, rd, wr, addr, mask, data, expErr, expData);
    tag = $sformatf("i%0d %s@%h", k, (rd && wr) ? "rdwr" : (wr ? "st" : "ld"), addr);
    applyStimulus(k, rd, wr, addr, mask, data);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 40) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      checkOutput({tag, " busy"}, {31'd0, obsBusy[k]}, 32'd1);
      if (obsValid[k]) seen = 1'b1;
    end
    gotData = obsData[k];
    gotErr  = obsErr[k];
    checkOutput({tag, " valid_seen"}, {31'd0, seen}, 32'd1);
    checkOutput({tag, " latency"}, cycles, latOf(k) + 1);
    checkOutput({tag, " err"}, {31'd0, gotErr}, {31'd0, expErr});
    checkOutput({tag, " data"}, gotData, expData);
    applyStimulus(k, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " valid_after"}, {31'd0, obsValid[k]}, 32'd0);
    checkOutput({tag, " busy_after"}, {31'd0, obsBusy[k]}, 32'd0);
  endtask

  function automatic logic [31:0] pickAddr(input int poolWords);
    logic [31:0] badList [4];
    int          sel;
    badList[0] = 32'h0000_2000;
    badList[1] = 32'h0000_0FFC;
    badList[2] = 32'hFFFF_FFFC;
    badList[3] = 32'h0000_2000 + 32'(4 * $urandom_range(0, 255));
    sel = $urandom_range(0, 9);
    if (sel == 0) begin
      return 32'h1000 + 32'(4 * $urandom_range(0, poolWords - 1)) + 32'($urandom_range(1, 3));
    end else if (sel == 1) begin
      return badList[$urandom_range(0, 3)];
    end
    return 32'h1000 + 32'(4 * $urandom_range(0, poolWords - 1));
  endfunction

  // Watchdog so the run can never hang.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    logic [31:0] v;
    logic [4:0]  vPat;
    logic [4:0]  bPat;
    int          pool;
    int          kind;

    reset = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);

    // Outputs must be quiet while reset is held.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("i%0d reset valid", k), {31'd0, obsValid[k]}, 32'd0);
      checkOutput($sformatf("i%0d reset err", k), {31'd0, obsErr[k]}, 32'd0);
      checkOutput($sformatf("i%0d reset busy", k), {31'd0, obsBusy[k]}, 32'd0);
      checkOutput($sformatf("i%0d reset data", k), obsData[k], 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);

    // Give every word the bench will read a known value.
    for (int k = 0; k < 3; k++) begin
      pool = (k == 0) ? 32 : 8;
      for (int w = 0; w <= pool; w++) begin
        int idx;
        idx = (w == pool) ? 1023 : w;
        if (idx == 3)      v = 32'h0;
        else if (idx == 2) v = 32'h1122_3344;
        else               v = $urandom | 32'h1;
        doRequest(k, 1'b0, 1'b1, 32'h1000 + 32'(4 * idx), 4'hF, v, d, e);
      end
    end

    // Directed cases on the single-wait-state instance.
    doRequest(0, 1'b0, 1'b1, 32'h1004, 4'b1111, 32'hDEAD_BEEF, d, e);
    doRequest(0, 1'b1, 1'b0, 32'h1004, 4'b0000, 32'h0, d, e);
    checkOutput("plan load 0x1004", d, 32'hDEAD_BEEF);
    doRequest(0, 1'b0, 1'b1, 32'h1008, 4'b0100, 32'hAABB_CCDD, d, e);
    doRequest(0, 1'b1, 1'b0, 32'h1008, 4'b1111, 32'h0, d, e);
    checkOutput("plan byte lane", d, 32'h11BB_3344);
    doRequest(0, 1'b1, 1'b0, 32'h1002, 4'b1111, 32'h0, d, e);
    checkOutput("plan misaligned err", {31'd0, e}, 32'd1);
    v = refMem[0][1023];
    doRequest(0, 1'b0, 1'b1, 32'h2000, 4'b1111, 32'h5555_AAAA, d, e);
    checkOutput("plan out of range err", {31'd0, e}, 32'd1);
    doRequest(0, 1'b1, 1'b0, 32'h1FFC, 4'b1111, 32'h0, d, e);
    checkOutput("plan 0x1FFC unchanged", d, v);
    v = refMem[0][4];
    doRequest(0, 1'b1, 1'b1, 32'h1010, 4'b1111, 32'h7777_7777, d, e);
    checkOutput("plan rd+wr err", {31'd0, e}, 32'd1);
    doRequest(0, 1'b1, 1'b0, 32'h1010, 4'b1111, 32'h0, d, e);
    checkOutput("plan 0x1010 unchanged", d, v);
    doRequest(0, 1'b0, 1'b1, 32'h1010, 4'b0000, 32'h9999_9999, d, e);
    checkOutput("plan mask0 err", {31'd0, e}, 32'd0);
    doRequest(0, 1'b1, 1'b0, 32'h1010, 4'b1111, 32'h0, d, e);
    checkOutput("plan mask0 no write", d, v);

    // A load held through the response: one pulse per LATENCY+2 cycles,
    // never re-accepted on the RESP->IDLE edge.
    applyStimulus(0, 1'b1, 1'b0, 32'h1008, 4'hF, 32'h0);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      @(negedge clk);
      vPat[n] = obsValid[0];
      bPat[n] = obsBusy[0];
    end
    applyStimulus(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("held valid pattern", {27'd0, vPat}, 32'b10010);
    checkOutput("held busy pattern", {27'd0, bPat}, 32'b11011);

    // Back-to-back loads on the zero and fifteen wait-state instances.
    for (int k = 1; k < 3; k++) begin
      doRequest(k, 1'b1, 1'b0, 32'h1008, 4'hF, 32'h0, d, e);
      doRequest(k, 1'b1, 1'b0, 32'h1004, 4'hF, 32'h0, d, e);
    end

    // Randomised traffic against the model.
    for (int k = 0; k < 3; k++) begin
      pool = (k == 0) ? 32 : 8;
      for (int n = 0; n < ((k == 0) ? 40 : ((k == 1) ? 25 : 8)); n++) begin
        kind = $urandom_range(0, 9);
        doRequest(k, (kind == 0) || (kind > 4), (kind >= 0) && (kind <= 4), pickAddr(pool),
                  4'($urandom_range(0, 15)), $urandom, d, e);
      end
    end

    // Reset in the middle of a store's wait states on the slow instance.
    doRequest(2, 1'b1, 1'b0, 32'h1014, 4'hF, 32'h0, d, e);
    checkOutput("pre-reset load nonzero", {31'd0, (d != 32'd0)}, 32'd1);
    v = refMem[0][2];
    applyStimulus(2, 1'b0, 1'b1, 32'h100C, 4'hF, 32'hCAFE_F00D);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("mid-wait busy", {31'd0, obsBusy[2]}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset valid", {31'd0, obsValid[2]}, 32'd0);
    checkOutput("async reset err", {31'd0, obsErr[2]}, 32'd0);
    checkOutput("async reset busy", {31'd0, obsBusy[2]}, 32'd0);
    checkOutput("async reset data", obsData[2], 32'd0);
    applyStimulus(2, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    doRequest(2, 1'b1, 1'b0, 32'h100C, 4'hF, 32'h0, d, e);
    checkOutput("aborted store absent", d, 32'h0);
    doRequest(0, 1'b1, 1'b0, 32'h1008, 4'hF, 32'h0, d, e);
    checkOutput("ram kept over reset", d, v);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
